// File: rtl/sm83_pkg.sv
// Shared SM83 core definitions: fetch FSM encoding, prefix opcode and the
// immediate-length table used by the fetch stage.
package sm83_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned LEN_W  = 2;
   localparam int unsigned ST_W   = 3;

   typedef logic [ST_W-1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE   = 3'd0;
   localparam fetch_state_t ST_OPCODE = 3'd1;
   localparam fetch_state_t ST_CB_OP  = 3'd2;
   localparam fetch_state_t ST_IMM_LO = 3'd3;
   localparam fetch_state_t ST_IMM_HI = 3'd4;
   localparam fetch_state_t ST_HOLD   = 3'd5;

   localparam logic [DATA_W-1:0] OP_CB_PREFIX = 8'hCB;

   // Number of immediate bytes following an unprefixed opcode; illegal opcodes count as 0.
   function automatic logic [1:0] imm_bytes(input logic [DATA_W-1:0] op);
      case (op)
         8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
         8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
         8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
         8'hE0, 8'hF0, 8'hE8, 8'hF8:
            imm_bytes = 2'd1;
         8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
         8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
         8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA:
            imm_bytes = 2'd2;
         default:
            imm_bytes = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch stage: owns PC, reads prefix/opcode/immediates over a
// byte-wide port and holds one instruction bundle for execute.
module sm83_fetch
   import sm83_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_cycle,
   input  logic                pc_load,
   input  logic [ADDR_W-1:0]   pc_load_value,
   output logic                mem_rd,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [DATA_W-1:0]   instr_opcode,
   output logic                instr_cb,
   output logic [ADDR_W-1:0]   instr_imm,
   output logic [LEN_W-1:0]    instr_len,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic [ADDR_W-1:0]   pc
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              rd_q, rd_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic              cb_q, cb_d;
   logic [ADDR_W-1:0] imm_q, imm_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;

   logic              ack;
   logic [ADDR_W-1:0] pc_inc;
   logic [LEN_W-1:0]  len_inc;

   assign ack     = rd_q & mem_ack;
   assign pc_inc  = ADDR_W'(pc_q + 16'd1);
   assign len_inc = LEN_W'(len_q + 2'd1);

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         rd_q    <= 1'b0;
         valid_q <= 1'b0;
         op_q    <= '0;
         cb_q    <= 1'b0;
         imm_q   <= '0;
         len_q   <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         cb_q    <= cb_d;
         imm_q   <= imm_d;
         len_q   <= len_d;
         ipc_q   <= ipc_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      op_d    = op_q;
      cb_d    = cb_q;
      imm_d   = imm_q;
      len_d   = len_q;
      ipc_d   = ipc_q;

      if (pc_load) begin
         // Redirect wins over everything; a concurrent ack is dropped.
         pc_d    = pc_load_value;
         rd_d    = 1'b0;
         valid_d = 1'b0;
         op_d    = '0;
         cb_d    = 1'b0;
         imm_d   = '0;
         len_d   = '0;
         ipc_d   = '0;
         state_d = ST_IDLE;
         if (state_q == ST_IDLE && fetch_cycle) begin
            state_d = ST_OPCODE;
            rd_d    = 1'b1;
            ipc_d   = pc_load_value;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fetch_cycle) begin
                  state_d = ST_OPCODE;
                  rd_d    = 1'b1;
                  ipc_d   = pc_q;
                  op_d    = '0;
                  cb_d    = 1'b0;
                  imm_d   = '0;
                  len_d   = '0;
               end
            end
            ST_OPCODE: begin
               if (ack) begin
                  op_d  = mem_rdata;
                  pc_d  = pc_inc;
                  len_d = 2'd1;
                  if (mem_rdata == OP_CB_PREFIX) begin
                     state_d = ST_CB_OP;
                  end else if (imm_bytes(mem_rdata) == 2'd0) begin
                     state_d = ST_HOLD;
                     rd_d    = 1'b0;
                     valid_d = 1'b1;
                  end else begin
                     state_d = ST_IMM_LO;
                  end
               end
            end
            ST_CB_OP: begin
               if (ack) begin
                  op_d    = mem_rdata;
                  cb_d    = 1'b1;
                  pc_d    = pc_inc;
                  len_d   = 2'd2;
                  state_d = ST_HOLD;
                  rd_d    = 1'b0;
                  valid_d = 1'b1;
               end
            end
            ST_IMM_LO: begin
               if (ack) begin
                  imm_d[7:0] = mem_rdata;
                  pc_d       = pc_inc;
                  len_d      = len_inc;
                  if (imm_bytes(op_q) == 2'd2) begin
                     state_d = ST_IMM_HI;
                  end else begin
                     state_d = ST_HOLD;
                     rd_d    = 1'b0;
                     valid_d = 1'b1;
                  end
               end
            end
            ST_IMM_HI: begin
               if (ack) begin
                  imm_d[15:8] = mem_rdata;
                  pc_d        = pc_inc;
                  len_d       = len_inc;
                  state_d     = ST_HOLD;
                  rd_d        = 1'b0;
                  valid_d     = 1'b1;
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               rd_d    = 1'b0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign mem_rd       = rd_q;
   assign mem_addr     = pc_q;
   assign instr_valid  = valid_q;
   assign instr_opcode = op_q;
   assign instr_cb     = cb_q;
   assign instr_imm    = imm_q;
   assign instr_len    = len_q;
   assign instr_pc     = ipc_q;
   assign pc           = pc_q;

endmodule

// File: tb/tb_sm83_fetch.sv
// Self-checking bench for sm83_fetch: byte memory model with programmable wait
// states and a queue of expected instruction bundles.
module tb_sm83_fetch;

   logic        clk;
   logic        rst_n;
   logic        fetch_cycle;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_opcode;
   logic        instr_cb;
   logic [15:0] instr_imm;
   logic [1:0]  instr_len;
   logic [15:0] instr_pc;
   logic [15:0] pc;

   typedef struct {
      logic [7:0]  op;
      logic        cb;
      logic [15:0] imm;
      logic [1:0]  len;
      logic [15:0] ipc;
      logic [15:0] pc_after;
   } bundle_t;

   bundle_t    sb[$];
   int         applied     = 0;
   int         miscompares = 0;
   int         waits       = 0;
   int         wcnt        = 0;
   logic [7:0] mem [0:65535];

   sm83_fetch #(.RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_cycle  (fetch_cycle),
      .pc_load      (pc_load),
      .pc_load_value(pc_load_value),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_opcode (instr_opcode),
      .instr_cb     (instr_cb),
      .instr_imm    (instr_imm),
      .instr_len    (instr_len),
      .instr_pc     (instr_pc),
      .pc           (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: 'waits' idle cycles, then one ack cycle per byte.
   always @(negedge clk) begin
      if (mem_rd && wcnt >= waits) begin
         mem_ack   = 1'b1;
         mem_rdata = mem[mem_addr];
         wcnt      = 0;
      end else if (mem_rd) begin
         mem_ack   = 1'b0;
         mem_rdata = 8'h00;
         wcnt      = wcnt + 1;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 8'h00;
         wcnt      = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      fetch_cycle = 1'b1;
      cyc();
      fetch_cycle = 1'b0;
   endtask

   task automatic load_pc(input logic [15:0] v);
      pc_load       = 1'b1;
      pc_load_value = v;
      cyc();
      pc_load       = 1'b0;
   endtask

   task automatic push(input logic [7:0] op, input logic cb, input logic [15:0] imm,
                       input logic [1:0] len, input logic [15:0] ipc, input logic [15:0] pa);
      bundle_t b;
      b.op = op; b.cb = cb; b.imm = imm; b.len = len; b.ipc = ipc; b.pc_after = pa;
      sb.push_back(b);
   endtask

   // Wait for the DUT's bundle, pop the scoreboard and compare every field.
   task automatic drain_bundle(input int budget, output int cycles);
      bundle_t e;
      cycles = 0;
      while (!instr_valid && cycles < budget) begin
         cyc();
         cycles++;
      end
      applied++;
      if (!instr_valid) begin
         miscompares++;
         $display("FAIL bundle_timeout: no instr_valid within %0d cycles", budget);
         if (sb.size() != 0) e = sb.pop_front();
      end else if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_bundle: op=%h with empty scoreboard", instr_opcode);
      end else begin
         e = sb.pop_front();
         applied += 5;
         if (instr_opcode !== e.op) begin
            miscompares++;
            $display("FAIL opcode: got %h want %h", instr_opcode, e.op);
         end
         if (instr_cb !== e.cb) begin
            miscompares++;
            $display("FAIL cb: got %b want %b", instr_cb, e.cb);
         end
         if (instr_imm !== e.imm) begin
            miscompares++;
            $display("FAIL imm: got %h want %h", instr_imm, e.imm);
         end
         if (instr_len !== e.len) begin
            miscompares++;
            $display("FAIL len: got %0d want %0d", instr_len, e.len);
         end
         if ({instr_pc, pc} !== {e.ipc, e.pc_after}) begin
            miscompares++;
            $display("FAIL instr_pc/pc: got %h/%h want %h/%h", instr_pc, pc, e.ipc, e.pc_after);
         end
      end
   endtask

   task automatic test_reset();
      int c;
      rst_n = 1'b0;
      cyc();
      cyc();
      applied++;
      if ({mem_rd, instr_valid, pc, mem_addr} !== {1'b0, 1'b0, 16'h0000, 16'h0000}) begin
         miscompares++;
         $display("FAIL reset_state: rd=%b valid=%b pc=%h addr=%h want 0/0/0000/0000",
                  mem_rd, instr_valid, pc, mem_addr);
      end
      applied++;
      if ({instr_opcode, instr_cb, instr_imm, instr_len, instr_pc} !== 43'd0) begin
         miscompares++;
         $display("FAIL reset_data: op=%h cb=%b imm=%h len=%0d ipc=%h want zeros",
                  instr_opcode, instr_cb, instr_imm, instr_len, instr_pc);
      end
      rst_n = 1'b1;
      cyc();
      push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000, 16'h0001);
      strobe();
      drain_bundle(20, c);
      applied++;
      if (c !== 1) begin
         miscompares++;
         $display("FAIL nop_latency: got %0d want 1", c);
      end
      cyc();
   endtask

   task automatic test_jump();
      int c;
      mem[16'h0100] = 8'hC3; mem[16'h0101] = 8'h50; mem[16'h0102] = 8'h01;
      load_pc(16'h0100);
      push(8'hC3, 1'b0, 16'h0150, 2'd3, 16'h0100, 16'h0103);
      strobe();
      drain_bundle(20, c);
      applied++;
      if (c !== 3) begin
         miscompares++;
         $display("FAIL jp_latency_0ws: got %0d want 3", c);
      end
      cyc();
      load_pc(16'h0100);
      waits = 2;
      push(8'hC3, 1'b0, 16'h0150, 2'd3, 16'h0100, 16'h0103);
      strobe();
      drain_bundle(40, c);
      applied++;
      if (c !== 9) begin
         miscompares++;
         $display("FAIL jp_latency_2ws: got %0d want 9", c);
      end
      waits = 0;
      cyc();
   endtask

   task automatic test_cb_prefix();
      int c;
      mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
      load_pc(16'h0200);
      push(8'h37, 1'b1, 16'h0000, 2'd2, 16'h0200, 16'h0202);
      strobe();
      drain_bundle(20, c);
      applied++;
      if (c !== 2) begin
         miscompares++;
         $display("FAIL cb_latency: got %0d want 2", c);
      end
      cyc();
   endtask

   task automatic test_backpressure();
      int c;
      mem[16'h0400] = 8'h06; mem[16'h0401] = 8'h77;
      load_pc(16'h0400);
      instr_ready = 1'b0;
      push(8'h06, 1'b0, 16'h0077, 2'd2, 16'h0400, 16'h0402);
      strobe();
      drain_bundle(20, c);
      for (int i = 0; i < 5; i++) begin
         fetch_cycle = (i == 1);
         cyc();
         applied++;
         if ({instr_valid, mem_rd, instr_opcode, instr_imm, instr_len, pc} !==
             {1'b1, 1'b0, 8'h06, 16'h0077, 2'd2, 16'h0402}) begin
            miscompares++;
            $display("FAIL hold_stable[%0d]: valid=%b rd=%b op=%h imm=%h len=%0d pc=%h",
                     i, instr_valid, mem_rd, instr_opcode, instr_imm, instr_len, pc);
         end
      end
      fetch_cycle = 1'b0;
      instr_ready = 1'b1;
      cyc();
      for (int i = 0; i < 4; i++) begin
         applied++;
         if ({instr_valid, mem_rd} !== 2'b00) begin
            miscompares++;
            $display("FAIL after_accept[%0d]: valid=%b rd=%b want 0/0", i, instr_valid, mem_rd);
         end
         cyc();
      end
   endtask

   task automatic test_wrap();
      int c;
      mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h42;
      load_pc(16'hFFFF);
      push(8'h3E, 1'b0, 16'h0042, 2'd2, 16'hFFFF, 16'h0001);
      strobe();
      drain_bundle(20, c);
      applied++;
      if (c !== 2) begin
         miscompares++;
         $display("FAIL wrap_latency: got %0d want 2", c);
      end
      cyc();
   endtask

   task automatic test_pc_load();
      int c;
      mem[16'h0300] = 8'h3E; mem[16'h0301] = 8'h99; mem[16'h0040] = 8'h00;
      load_pc(16'h0300);
      strobe();
      cyc();
      applied++;
      if ({mem_rd, pc} !== {1'b1, 16'h0301}) begin
         miscompares++;
         $display("FAIL imm_lo_entry: rd=%b pc=%h want 1/0301", mem_rd, pc);
      end
      pc_load       = 1'b1;
      pc_load_value = 16'h0038;
      cyc();
      pc_load       = 1'b0;
      applied++;
      if ({pc, mem_addr, mem_rd, instr_valid} !== {16'h0038, 16'h0038, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL redirect: pc=%h addr=%h rd=%b valid=%b want 0038/0038/0/0",
                  pc, mem_addr, mem_rd, instr_valid);
      end
      for (int i = 0; i < 5; i++) begin
         cyc();
         applied++;
         if ({instr_valid, mem_rd, pc} !== {1'b0, 1'b0, 16'h0038}) begin
            miscompares++;
            $display("FAIL redirect_idle[%0d]: valid=%b rd=%b pc=%h", i, instr_valid, mem_rd, pc);
         end
      end
      push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0040, 16'h0041);
      pc_load       = 1'b1;
      pc_load_value = 16'h0040;
      fetch_cycle   = 1'b1;
      cyc();
      pc_load       = 1'b0;
      fetch_cycle   = 1'b0;
      applied++;
      if ({mem_rd, mem_addr} !== {1'b1, 16'h0040}) begin
         miscompares++;
         $display("FAIL load_and_fetch: rd=%b addr=%h want 1/0040", mem_rd, mem_addr);
      end
      drain_bundle(20, c);
      cyc();
   endtask

   task automatic test_mid_reset();
      mem[16'h0500] = 8'hC3;
      load_pc(16'h0500);
      waits = 3;
      strobe();
      cyc();
      rst_n = 1'b0;
      #1;
      applied++;
      if ({mem_rd, instr_valid, pc} !== {1'b0, 1'b0, 16'h0000}) begin
         miscompares++;
         $display("FAIL async_reset: rd=%b valid=%b pc=%h want 0/0/0000", mem_rd, instr_valid, pc);
      end
      cyc();
      rst_n = 1'b1;
      waits = 0;
      cyc();
      cyc();
      applied++;
      if ({mem_rd, instr_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL post_reset_idle: rd=%b valid=%b want 0/0", mem_rd, instr_valid);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      rst_n         = 1'b0;
      fetch_cycle   = 1'b0;
      pc_load       = 1'b0;
      pc_load_value = 16'h0000;
      instr_ready   = 1'b1;
      mem_ack       = 1'b0;
      mem_rdata     = 8'h00;

      test_reset();
      test_jump();
      test_cb_prefix();
      test_backpressure();
      test_wrap();
      test_pc_load();
      test_mid_reset();

      applied++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
